// File: rtl/bit_stat_pkg.sv
// Shared types and defaults for the bit statistics unit.
package bit_stat_pkg;

  localparam int BS_DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    BS_ONES  = 2'b00,
    BS_ZEROS = 2'b01,
    BS_LZ    = 2'b10,
    BS_TZ    = 2'b11
  } bs_mode_t;

  typedef enum logic [1:0] {
    BS_IDLE = 2'b00,
    BS_RUN  = 2'b01,
    BS_DONE = 2'b10
  } bs_state_t;

endpackage

// File: rtl/bs_shift_reg.sv
// Operand register: parallel load takes priority over a left shift with zero fill.
module bs_shift_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift_en,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] reg_q;

  // Operand storage with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_q <= '0;
    end else if (load) begin
      reg_q <= data_in;
    end else if (shift_en) begin
      reg_q <= {reg_q[DATA_W-2:0], 1'b0};
    end else begin
      reg_q <= reg_q;
    end
  end

  assign q = reg_q;

endmodule

// File: rtl/bit_stat_unit.sv
// Serial bit statistics: counts ones, zeros, leading or trailing zeros by
// scanning the operand MSB-first, one bit per clock.
module bit_stat_unit
  import bit_stat_pkg::*;
#(
  parameter int DATA_W = BS_DATA_W_DEF,
  parameter int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] data,
  output logic [CNT_W-1:0]  count,
  output logic              rdy,
  output logic              done
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] ONE_CNT  = {{(CNT_W-1){1'b0}}, 1'b1};

  bs_state_t         state_q, state_d;
  bs_mode_t          mode_q, mode_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              rdy_q, rdy_d;
  logic              done_q, done_d;
  logic              ld_s, shift_s, counting_s;
  logic [DATA_W-1:0] rev_s, opnd_s, reg_s;

  // Trailing zeros become leading zeros once the operand is mirrored
  for (genvar i = 0; i < DATA_W; i++) begin : g_rev
    assign rev_s[i] = data[DATA_W-1-i];
  end

  // Operand pre-conditioning selected by the incoming mode
  always_comb begin
    opnd_s = data;
    case (bs_mode_t'(mode))
      BS_ZEROS: opnd_s = ~data;
      BS_TZ:    opnd_s = rev_s;
      default:  opnd_s = data;
    endcase
  end

  bs_shift_reg #(
    .DATA_W(DATA_W)
  ) u_shift (
    .clk     (clk),
    .rst     (rst),
    .load    (ld_s),
    .shift_en(shift_s),
    .data_in (opnd_s),
    .q       (reg_s)
  );

  assign counting_s = (mode_q == BS_ONES) || (mode_q == BS_ZEROS);

  // Next-state, count update and operand register control
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    count_d = count_q;
    ld_s    = 1'b0;
    shift_s = 1'b0;
    case (state_q)
      BS_IDLE: begin
        if (start) begin
          ld_s    = 1'b1;
          count_d = '0;
          mode_d  = bs_mode_t'(mode);
          state_d = BS_RUN;
        end else begin
          state_d = BS_IDLE;
        end
      end
      BS_RUN: begin
        if (counting_s) begin
          if (reg_s == '0) begin
            state_d = BS_DONE;
          end else begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, reg_s[DATA_W-1]};
            shift_s = 1'b1;
          end
        end else begin
          // Leading-zero scan stops at the first one; an all-zero operand is full width
          if (reg_s == '0) begin
            count_d = FULL_CNT;
            state_d = BS_DONE;
          end else if (reg_s[DATA_W-1]) begin
            state_d = BS_DONE;
          end else begin
            count_d = count_q + ONE_CNT;
            shift_s = 1'b1;
          end
        end
      end
      BS_DONE: state_d = BS_IDLE;
      default: state_d = BS_IDLE;
    endcase
    rdy_d  = (state_d == BS_IDLE);
    done_d = (state_d == BS_DONE);
  end

  // State, latched mode, result and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BS_IDLE;
      mode_q  <= BS_ONES;
      count_q <= '0;
      rdy_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      count_q <= count_d;
      rdy_q   <= rdy_d;
      done_q  <= done_d;
    end
  end

  assign count = count_q;
  assign rdy   = rdy_q;
  assign done  = done_q;

endmodule

// File: doc/bit_stat_unit.md
BIT_STAT_UNIT -- requirements
Module: bit_stat_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand width (>=2).
REQ-002 SHALL have parameter CNT_W, default $clog2(DATA_W+1), result width; must hold the value DATA_W.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port start  input  1  request; accepted only when rdy=1.
REQ-006 SHALL have port mode  input  2  operation select, sampled with start: 00 count ones, 01 count zeros, 10 leading zeros, 11 trailing zeros.
REQ-007 SHALL have port data  input  DATA_W  operand, sampled with start.
REQ-008 SHALL have port count  output  CNT_W  result.
REQ-009 SHALL have port rdy  output  1  high in IDLE only.
REQ-010 SHALL have port done  output  1  one-cycle pulse; result valid.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE.
REQ-012 IDLE: rdy=1; start=1 at an edge loads the operand register, clears count, latches mode, and moves to RUN.
REQ-013 Operand load SHALL be: modes 00 and 10 data; mode 01 ~data; mode 11 data bit-reversed (data[0] into MSB).
REQ-014 RUN, modes 00/01: register==0 -> DONE with no count change; else count += MSB, shift left with 0 fill.
REQ-015 RUN, modes 10/11: register==0 -> count=DATA_W and DONE; MSB=1 -> DONE with no count change; else count += 1 and shift left.
REQ-016 Worst-case latency SHALL be DATA_W+2 edges from start acceptance to done high; the zero-operand cases in modes 00 and 10 SHALL take exactly 2 edges.
REQ-017 DONE SHALL last exactly one cycle: done=1, rdy=0; then IDLE.
REQ-018 count SHALL hold the result stable from done until the next accepted start.
REQ-019 start, mode and data changes SHALL be ignored in RUN and DONE; there is no queuing.
REQ-020 start held high continuously SHALL begin a new operation on the first IDLE edge after DONE.
REQ-021 count SHALL never exceed DATA_W and SHALL never wrap.

Reset
REQ-022 rst=1 at a clock edge SHALL force IDLE, count=0, done=0, operand register=0, and latched mode=00; rdy=1 in the following cycle.
REQ-023 Reset SHALL take priority over start and over any operation in progress (abort mid-RUN); no done pulse is produced for an aborted operation.
REQ-024 There SHALL be no asynchronous reset path.

Structure
REQ-025 Shared package bit_stat_pkg SHALL hold: enum bs_mode_t {BS_ONES, BS_ZEROS, BS_LZ, BS_TZ}, enum bs_state_t {BS_IDLE, BS_RUN, BS_DONE}, and the default DATA_W constant.
REQ-026 Operand storage SHALL be a sub-module bs_shift_reg (parameter DATA_W; ports clk, rst, load, shift_en, data_in, q) with load priority over shift.
REQ-027 The FSM, mode pre-conditioning and count register SHALL be in the top module.

Verification (DATA_W=8)
REQ-028 Mode 00, data 8'hB5 -> count=5, one done pulse within 10 edges, rdy low until after done.
REQ-029 Mode 01, data 8'hB5 -> count=3; mode 00, data 8'h00 -> count=0 with done on the 2nd edge after acceptance.
REQ-030 Mode 10, data 8'h10 -> count=3; mode 11, data 8'h10 -> count=4; mode 10, data 8'h00 -> count=8; mode 11, data 8'h01 -> count=0.
REQ-031 Mode 00, data 8'hFF, with start pulsed again and data changed to 8'h00 during RUN -> the second start is ignored; count=8.
REQ-032 rst asserted on the 3rd RUN cycle of a mode 00 / 8'hFF operation -> next cycle: rdy=1, count=0, no done pulse; a following mode 00 / 8'h0F operation -> count=4.
